fos_iir_mc: RTL
===============

Name: fos_iir_mc

Overview:
Parametrised, time-multiplexed first-order recursive filter (transposed form I: y = x + s, s_next = a1·y) serving NCH independent channels.
- Per-channel state and per-channel coefficient registers.
- Iterative radix-4 Booth multiplier, so one multiplier is shared across channels.
- Valid/ready handshake on both input and output sides.
- Selectable wrap or saturating arithmetic.
- Sits in the filter datapath as the multi-channel successor of the single-channel fixed-width first-order section.

Parameters:
- DW, 32, data width of x_in/y_out/state (signed two's complement)
- CW, 11, coefficient width, signed Q1.(CW-1) fraction
- NCH, 4, number of channels
- CHW, 2, channel index width; must equal max(1, clog2(NCH))
- SAT, 0, 0 = wrap on overflow, 1 = saturate to signed DW range

Ports:
- clk, in, 1, clock
- reset, in, 1, synchronous, active-high reset
- in_valid, in, 1, sample offered
- in_ready, out, 1, block can accept a sample this cycle
- in_ch, in, CHW, channel of offered sample
- x_in, in, DW, signed input sample
- coef_we, in, 1, coefficient write strobe
- coef_ch, in, CHW, channel addressed by coef_we
- coef_data, in, CW, signed coefficient a1
- out_valid, out, 1, y_out/out_ch valid
- out_ready, in, 1, downstream accepts output
- out_ch, out, CHW, channel of y_out
- y_out, out, DW, signed filter output

Behaviour:
- Clocking and reset: clk is the clock; reset is synchronous and active-high.
- On reset:
  - all state[ch] = 0 and coef[ch] = 0;
  - FSM goes to IDLE;
  - out_valid = 0, y_out = 0, out_ch = 0;
  - in_ready = 0 during the reset cycle and 1 in the cycle after.
  - A reset asserted mid-operation aborts the multiply; no state writeback occurs.
- FSM states: IDLE, MUL, WB.
- in_ready = (state == IDLE) && (!out_valid || out_ready).
- Accept occurs at cycle T when in_valid && in_ready. At the T edge:
  - y = x_in + state[in_ch], computed at DW+1 bits, then wrapped (SAT=0) or clamped to [-2^(DW-1), 2^(DW-1)-1] (SAT=1);
  - y_out <= y, out_ch <= in_ch, out_valid <= 1;
  - the block latches y, in_ch and coef[in_ch] as operands;
  - FSM -> MUL, iteration counter = 0.
- Output latency: y_out is valid from cycle T+1. out_valid and y_out stay stable until out_ready is sampled high; out_valid then drops unless a new sample is accepted in the same cycle.
- MUL:
  - NITER = ceil(CW/2) cycles, one radix-4 Booth digit per cycle.
  - Accumulates the exact signed product P (DW+CW bits) of y and the latched coefficient.
  - After NITER cycles -> WB.
- WB (1 cycle):
  - s = P >>> (CW-1), arithmetic shift, i.e. floor;
  - s is wrapped or saturated to DW per SAT;
  - state[ch] <= s; FSM -> IDLE.
- Throughput: one sample per NITER+2 cycles at most (8 cycles for CW=11). Channel order is arbitrary; the same channel may be issued back-to-back.
- Coefficient writes:
  - accepted in any cycle and any state; take effect from the next cycle.
  - An in-flight sample always uses the coefficient latched at its accept.
  - A write to a channel in the same cycle as an accept on that channel: the sample uses the old value.
- in_ch/coef_ch >= NCH: accept/write is ignored (no state change, no output); in_ready behaviour is unchanged.
- Coefficient -2^(CW-1) (= -1.0) is legal and must be exact.

Test Plan:
- Defaults (DW=32, CW=11, NCH=4, SAT=0). Reset, coef[0]=512 (0.5), ch0 x = 1000, 0, 0, 0 -> y_out = 1000, 500, 250, 125. First out_valid one cycle after accept; accepts spaced 8 cycles apart.
- Channel isolation: coef[1]=-512, interleave ch0 x=1000, 0, 0 with ch1 x=1000, 0, 0 -> ch0 gives 1000, 500, 250; ch1 gives 1000, -500, 250; out_ch is correct on every output.
- Overflow, coef[0]=1023, x=0x7FFFFFF0 twice:
  - SAT=1: second y = 0x7FFFFFFF;
  - SAT=0: second y is negative (wrapped), matching a DW-bit modular reference model.
- Backpressure: hold out_ready=0 after the first output -> out_valid stays 1, y_out stable, in_ready=0 indefinitely. Raise out_ready -> in_ready=1 that cycle, and the next sample is accepted.
- Coefficient collision: coef[0]=512, then accept x=1000 on ch0 while writing coef[0]=0 in the same cycle. Next x=0 -> y=500; the following x=0 -> y=0.
- Reset mid-MUL: coef[2]=512, accept x=1000 on ch2, assert reset 3 cycles later -> out_valid=0, y_out=0. After reset, coef[2]=512 and x=7 on ch2 -> y=7, confirming the state was cleared and no writeback occurred.

Source files
------------

// File: rtl/fos_iir_mc.sv
// fos_iir_mc -- time-multiplexed first-order recursive filter section.
//
// Each channel runs y = x + s, s_next = a1 * y. The channels share one
// iterative radix-4 Booth multiplier. A sample is accepted in IDLE, and its
// output is registered on the same edge. The feedback product is then built
// over NITER = ceil(CW/2) MUL cycles and written back to the channel state in
// a single WB cycle.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_ready   input handshake; in_ch selects the channel, x_in is the sample
//   coef_we/coef_ch     coefficient write strobe and channel, coef_data = a1 (Q1.CW-1)
//   out_valid/out_ready output handshake; out_ch/y_out carry the filtered sample
module fos_iir_mc #(
    parameter int DW  = 32,
    parameter int CW  = 11,
    parameter int NCH = 4,
    parameter int CHW = 2,
    parameter int SAT = 0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [CHW-1:0] in_ch,
    input  logic [DW-1:0]  x_in,
    input  logic           coef_we,
    input  logic [CHW-1:0] coef_ch,
    input  logic [CW-1:0]  coef_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [CHW-1:0] out_ch,
    output logic [DW-1:0]  y_out
);

    localparam int NITER = (CW + 1) / 2;
    localparam int MW    = 2 * NITER + 1;       // Booth multiplier bits incl. the implicit 0 below the LSB
    localparam int PW    = DW + 2 * NITER + 2;  // product accumulator, headroom for partial sums
    localparam int ITW   = $clog2(NITER + 1);
    localparam logic [CHW:0] NCH_C = (CHW + 1)'(NCH);

    typedef enum logic [1:0] {IDLE, MUL, WB} state_t;

    // Wraps or clamps a wide signed value into the signed DW range.
    function automatic logic signed [DW-1:0] fit_dw(input logic signed [PW-1:0] v);
        logic signed [PW-1:0] hi;
        logic signed [PW-1:0] lo;
        hi = {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};
        lo = {{(PW-DW+1){1'b1}}, {(DW-1){1'b0}}};
        if (SAT != 0 && v > hi) return hi[DW-1:0];
        if (SAT != 0 && v < lo) return lo[DW-1:0];
        return v[DW-1:0];
    endfunction

    // One radix-4 Booth partial product: digit in {-2,-1,0,+1,+2} times m.
    function automatic logic signed [PW-1:0] booth_pp(input logic [2:0] dig,
                                                      input logic signed [PW-1:0] m);
        case (dig)
            3'b001, 3'b010: booth_pp = m;
            3'b011:         booth_pp = m <<< 1;
            3'b100:         booth_pp = -(m <<< 1);
            3'b101, 3'b110: booth_pp = -m;
            default:        booth_pp = '0;
        endcase
    endfunction

    state_t               state, state_nxt;
    logic [ITW-1:0]       iter;
    logic signed [DW-1:0] st_mem   [NCH];
    logic signed [CW-1:0] coef_mem [NCH];

    logic                 ch_ok, coef_ok, accept, mul_last;
    logic signed [DW-1:0] st_sel;
    logic signed [CW-1:0] coef_sel;
    logic signed [DW:0]   sum_p0;
    logic signed [DW-1:0] y_p0;
    logic signed [PW-1:0] y_ext;
    logic signed [MW-2:0] coef_ext;
    logic signed [DW-1:0] s_wb;

    logic signed [PW-1:0] mcand_p1, acc_p1;
    logic [MW-1:0]        mplr_p1;
    logic [CHW-1:0]       ch_p1;

    assign ch_ok    = {1'b0, in_ch} < NCH_C;
    assign coef_ok  = {1'b0, coef_ch} < NCH_C;
    assign in_ready = !reset && (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready && ch_ok;
    assign mul_last = (iter == ITW'(NITER - 1));

    // Stage p0: forward sum at accept, at DW+1 bits before wrap/clamp.
    always_comb begin
        st_sel   = st_mem[in_ch];
        coef_sel = coef_mem[in_ch];
        sum_p0   = {st_sel[DW-1], st_sel} + {x_in[DW-1], x_in};
        y_p0     = fit_dw({{(PW-DW-1){sum_p0[DW]}}, sum_p0});
        y_ext    = y_p0;
        coef_ext = coef_sel;
        s_wb     = fit_dw(acc_p1 >>> (CW - 1));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = MUL;
            MUL:     if (mul_last) state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            iter  <= '0;
        end else begin
            state <= state_nxt;
            if (accept)
                iter <= '0;
            else if (state == MUL)
                iter <= iter + 1'b1;
        end
    end

    // Stage p1: operands latched at accept, then one Booth digit per MUL cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            mcand_p1 <= y_ext;
            mplr_p1  <= {coef_ext, 1'b0};
            acc_p1   <= '0;
            ch_p1    <= in_ch;
        end else if (state == MUL) begin
            acc_p1   <= acc_p1 + booth_pp(mplr_p1[2:0], mcand_p1);
            mcand_p1 <= mcand_p1 <<< 2;
            mplr_p1  <= mplr_p1 >> 2;
        end
    end

    // Stage p2: writeback of the scaled product; coefficient writes land here too.
    // An accept reads coef_mem before a same-cycle write to it takes effect.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                st_mem[i]   <= '0;
                coef_mem[i] <= '0;
            end
        end else begin
            if (state == WB)
                st_mem[ch_p1] <= s_wb;
            if (coef_we && coef_ok)
                coef_mem[coef_ch] <= coef_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            y_out     <= '0;
            out_ch    <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            y_out     <= y_p0;
            out_ch    <= in_ch;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
